// File: rtl/aes_pkg.sv
// AES-128 constants, types and byte/word helpers used by the AddRoundKey and key-schedule logic.
package aes_pkg;

    localparam int         AES_NR    = 10;
    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_POLY = 8'h1B;

    typedef logic [127:0] state_t;
    typedef logic [127:0] key_t;
    typedef logic [31:0]  word_t;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] sbox_byte(input logic [7:0] b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: current round key + rcon -> next round key (combinational).
module aes_key_step
    import aes_pkg::*;
(
    input  key_t       kreg_i,
    input  logic [7:0] rcon_i,
    output key_t       rk_o
);

    word_t w0, w1, w2, w3;
    word_t rot, sub, t;
    word_t n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = kreg_i;
    assign rot = rot_word(w3);

    for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
        assign sub[8*gi +: 8] = sbox_byte(rot[8*gi +: 8]);
    end

    assign t  = sub ^ {rcon_i, 24'h0};
    assign n0 = w0 ^ t;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign rk_o = {n0, n1, n2, n3};

endmodule

// File: rtl/add_round_key_stage.sv
// Registered AES-128 AddRoundKey stage (rounds 1..10) with on-the-fly key expansion.
// Optional in_last/round consistency flag enabled by defining ARK_LAST_CHECK_EN.
module add_round_key_stage
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = AES_NR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_load,
    input  logic [127:0] cipher_key,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic [3:0]   out_round,
    output logic         out_last,
    output logic         key_valid,
    output logic         err
);

    key_t       kreg_q, kreg_d, korig_q, korig_d, rk;
    logic [3:0] round_q, round_d;
    logic [7:0] rcon_q, rcon_d;
    logic       key_valid_q, key_valid_d;
    logic       out_valid_q, out_valid_d;
    state_t     out_state_q, out_state_d;
    logic [3:0] out_round_q, out_round_d;
    logic       out_last_q, out_last_d;
    logic       err_q, err_d;
    logic       accept, last_rnd;

    aes_key_step u_key_step (
        .kreg_i (kreg_q),
        .rcon_i (rcon_q),
        .rk_o   (rk)
    );

    assign in_ready = key_valid_q & ~key_load & (~out_valid_q | out_ready);
    assign accept   = in_valid & in_ready;
    assign last_rnd = (round_q == 4'(NUM_ROUNDS));

`ifndef ARK_LAST_CHECK_EN
    logic unused_in_last;
    assign unused_in_last = in_last;
`endif

    always_comb begin
        kreg_d      = kreg_q;
        korig_d     = korig_q;
        round_d     = round_q;
        rcon_d      = rcon_q;
        key_valid_d = key_valid_q;
        out_valid_d = out_valid_q;
        out_state_d = out_state_q;
        out_round_d = out_round_q;
        out_last_d  = out_last_q;
        err_d       = err_q;
        if (key_load) begin
            kreg_d      = cipher_key;
            korig_d     = cipher_key;
            round_d     = 4'd1;
            rcon_d      = RCON_INIT;
            key_valid_d = 1'b1;
            out_valid_d = 1'b0;
            err_d       = 1'b0;
        end else if (accept) begin
            out_state_d = in_state ^ rk;
            out_round_d = round_q;
            out_last_d  = last_rnd;
            out_valid_d = 1'b1;
            // After the final round rewind to the cipher key for the next block.
            if (last_rnd) begin
                kreg_d  = korig_q;
                round_d = 4'd1;
                rcon_d  = RCON_INIT;
            end else begin
                kreg_d  = rk;
                round_d = round_q + 4'd1;
                rcon_d  = xtime(rcon_q);
            end
`ifdef ARK_LAST_CHECK_EN
            if (in_last != last_rnd) err_d = 1'b1;
`endif
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
`ifndef ARK_LAST_CHECK_EN
        err_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kreg_q      <= '0;
            korig_q     <= '0;
            round_q     <= 4'd1;
            rcon_q      <= RCON_INIT;
            key_valid_q <= 1'b0;
            out_valid_q <= 1'b0;
            out_state_q <= '0;
            out_round_q <= '0;
            out_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            kreg_q      <= kreg_d;
            korig_q     <= korig_d;
            round_q     <= round_d;
            rcon_q      <= rcon_d;
            key_valid_q <= key_valid_d;
            out_valid_q <= out_valid_d;
            out_state_q <= out_state_d;
            out_round_q <= out_round_d;
            out_last_q  <= out_last_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_state = out_state_q;
    assign out_round = out_round_q;
    assign out_last  = out_last_q;
    assign key_valid = key_valid_q;
    assign err       = err_q;

endmodule

// File: tb/tb_add_round_key_stage.sv
// Directed bench for add_round_key_stage using the FIPS-197 AES-128 example key schedule.
module tb_add_round_key_stage;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_load;
    logic [127:0] cipher_key;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic [3:0]   out_round;
    logic         out_last;
    logic         key_valid;
    logic         err;

    int checks   = 0;
    int failures = 0;

`ifdef ARK_LAST_CHECK_EN
    localparam logic LAST_CHK = 1'b1;
`else
    localparam logic LAST_CHK = 1'b0;
`endif

    add_round_key_stage dut (
        .clk        (clk),
        .rst        (rst),
        .key_load   (key_load),
        .cipher_key (cipher_key),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_state   (in_state),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_state  (out_state),
        .out_round  (out_round),
        .out_last   (out_last),
        .key_valid  (key_valid),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] st;
        logic         last_in;
        logic [127:0] rk;
        logic [3:0]   rnd;
        logic         lst;
    } vec_t;

    vec_t         vt[11];
    logic [127:0] rks[10];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_key_load();
        @(negedge clk);
        key_load = 1'b1;
        @(negedge clk);
        key_load = 1'b0;
    endtask

    // Streams n table entries back to back; each result is checked one cycle after it is driven.
    task automatic run_table(input int n);
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk($sformatf("v%0d_valid", i-1), 128'(out_valid), 128'(1'b1));
                chk($sformatf("v%0d_state", i-1), out_state, vt[i-1].st ^ vt[i-1].rk);
                chk($sformatf("v%0d_round", i-1), 128'(out_round), 128'(vt[i-1].rnd));
                chk($sformatf("v%0d_last", i-1), 128'(out_last), 128'(vt[i-1].lst));
            end
            if (i < n) begin
                in_valid = 1'b1;
                in_state = vt[i].st;
                in_last  = vt[i].last_in;
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
        end
    endtask

    initial begin
        rks[0] = 128'ha0fafe1788542cb123a339392a6c7605;
        rks[1] = 128'hf2c295f27a96b9435935807a7359f67f;
        rks[2] = 128'h3d80477d4716fe3e1e237e446d7a883b;
        rks[3] = 128'hef44a541a8525b7fb671253bdb0bad00;
        rks[4] = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        rks[5] = 128'h6d88a37a110b3efddbf98641ca0093fd;
        rks[6] = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        rks[7] = 128'head27321b58dbad2312bf5607f8d292f;
        rks[8] = 128'hac7766f319fadc2128d12941575c006e;
        rks[9] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        for (int i = 0; i < 11; i++) begin
            vt[i].st      = '0;
            vt[i].last_in = (i == 9);
            vt[i].rk      = rks[i % 10];
            vt[i].rnd     = 4'((i % 10) + 1);
            vt[i].lst     = (i == 9);
        end
        vt[2].st = {4{32'hffffffff}};
        vt[4].st = 128'h0123456789abcdeffedcba9876543210;
        vt[7].st = 128'h00112233445566778899aabbccddeeff;

        rst        = 1'b1;
        key_load   = 1'b0;
        cipher_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        in_valid   = 1'b0;
        in_state   = '0;
        in_last    = 1'b0;
        out_ready  = 1'b1;

        #1;
        chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("rst_out_state", out_state, 128'h0);
        chk("rst_out_round", 128'(out_round), 128'h0);
        chk("rst_key_valid", 128'(key_valid), 128'(1'b0));
        chk("rst_err", 128'(err), 128'(1'b0));
        chk("rst_in_ready", 128'(in_ready), 128'(1'b0));

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // No key yet: beats are refused.
        in_valid = 1'b1;
        @(negedge clk);
        chk("nokey_in_ready", 128'(in_ready), 128'(1'b0));
        @(negedge clk);
        chk("nokey_out_valid", 128'(out_valid), 128'(1'b0));
        in_valid = 1'b0;

        // Full block plus wrap into the next block.
        do_key_load();
        chk("kl_key_valid", 128'(key_valid), 128'(1'b1));
        run_table(11);
        chk("table_err", 128'(err), 128'(1'b0));
        @(negedge clk);
        chk("table_drain", 128'(out_valid), 128'(1'b0));

        // Backpressure, then drain and accept in the same cycle.
        do_key_load();
        in_valid  = 1'b1;
        in_state  = '0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("bp_valid", 128'(out_valid), 128'(1'b1));
        chk("bp_state", out_state, rks[0]);
        in_state = {4{32'h11111111}};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d_ready", k), 128'(in_ready), 128'(1'b0));
            chk($sformatf("bp_hold%0d_state", k), out_state, rks[0]);
            chk($sformatf("bp_hold%0d_round", k), 128'(out_round), 128'h1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 128'(in_ready), 128'(1'b1));
        @(negedge clk);
        chk("bp_next_valid", 128'(out_valid), 128'(1'b1));
        chk("bp_next_state", out_state, {4{32'h11111111}} ^ rks[1]);
        chk("bp_next_round", 128'(out_round), 128'h2);

        // Round 3 with a misplaced in_last.
        in_state = '0;
        in_last  = 1'b1;
        @(negedge clk);
        chk("r3_round", 128'(out_round), 128'h3);
        chk("r3_state", out_state, rks[2]);
        chk("r3_err", 128'(err), 128'(LAST_CHK));
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("r3_err_sticky", 128'(err), 128'(LAST_CHK));
        chk("r3_held_valid", 128'(out_valid), 128'(1'b1));

        // key_load at round 4 wins over the pending handshakes.
        key_load  = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("kl_in_ready", 128'(in_ready), 128'(1'b0));
        @(negedge clk);
        chk("kl_out_valid", 128'(out_valid), 128'(1'b0));
        chk("kl_err_clr", 128'(err), 128'(1'b0));
        key_load = 1'b0;
        @(negedge clk);
        chk("kl_next_round", 128'(out_round), 128'h1);
        chk("kl_next_state", out_state, rks[0]);
        in_valid = 1'b0;

        // Asynchronous reset in the middle of round 6.
        do_key_load();
        run_table(5);
        @(negedge clk);
        in_valid = 1'b1;
        in_state = vt[5].st;
        @(posedge clk);
        #2;
        chk("pre_rst_valid", 128'(out_valid), 128'(1'b1));
        chk("pre_rst_round", 128'(out_round), 128'h6);
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("arst_out_state", out_state, 128'h0);
        chk("arst_out_round", 128'(out_round), 128'h0);
        chk("arst_key_valid", 128'(key_valid), 128'(1'b0));
        chk("arst_in_ready", 128'(in_ready), 128'(1'b0));
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d_ready", k), 128'(in_ready), 128'(1'b0));
            chk($sformatf("post_rst%0d_valid", k), 128'(out_valid), 128'(1'b0));
        end
        in_valid = 1'b0;
        do_key_load();
        in_valid = 1'b1;
        in_state = '0;
        @(negedge clk);
        chk("post_rst_round", 128'(out_round), 128'h1);
        chk("post_rst_state", out_state, rks[0]);
        in_valid = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
